// File: rtl/u_dmem.sv
// Byte-lane data memory for the core data port: registered reads, per-lane writes
// and an out-of-range error pulse. Define DMEM_CLEAR_EN to zero the array after reset.
module u_dmem #(
  parameter int AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] dat_a,
  input  logic [3:0]  dat_we,
  input  logic [31:0] dat_wd,
  input  logic [3:0]  dat_re,
  output logic [31:0] dat_rd,
  output logic        init_done,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

  logic [31:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [31:0]   dat_rd_q;
  logic          err_q;
  logic          init_done_q;

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          req_any;
  logic [31:0]   re_mask;

  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_idx;
  logic [3:0]    mem_wr_be;
  logic [31:0]   mem_wr_data;

`ifdef DMEM_CLEAR_EN
  logic [AW-1:0] clr_idx_q;
`endif

  // The two low address bits select a byte inside the word and play no part here.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^dat_a[1:0];

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    word_idx = dat_a[AW+1:2];
    in_range = (dat_a[15:AW+2] == '0);
    req_any  = (dat_we != 4'h0) || (dat_re != 4'h0);
    re_mask  = '0;
    for (int i = 0; i < 4; i++) begin
      re_mask[8*i +: 8] = {8{dat_re[i]}};
    end
  end

  // Single write port shared by the clear sweep and core writes.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_wr_idx  = word_idx;
    mem_wr_be   = dat_we;
    mem_wr_data = dat_wd;
    if (!rst && state_q == ST_READY && in_range && dat_we != 4'h0) begin
      mem_wr_en = 1'b1;
    end
`ifdef DMEM_CLEAR_EN
    if (!rst && state_q == ST_CLEAR) begin
      mem_wr_en   = 1'b1;
      mem_wr_idx  = clr_idx_q;
      mem_wr_be   = 4'hF;
      mem_wr_data = '0;
    end
`endif
  end

  // NOTE: the array has no reset branch; it maps onto RAM, and its contents are zeroed only by the clear sweep.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wr_be[i]) begin
          mem_q[mem_wr_idx][8*i +: 8] <= mem_wr_data[8*i +: 8];
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments, so the read below sees the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      dat_rd_q    <= '0;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
`ifdef DMEM_CLEAR_EN
      clr_idx_q   <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_CLEAR: begin
`ifdef DMEM_CLEAR_EN
          clr_idx_q <= clr_idx_q + AW'(1);
          if (&clr_idx_q) begin
            state_q     <= ST_READY;
            init_done_q <= 1'b1;
          end
`else
          state_q     <= ST_READY;
          init_done_q <= 1'b1;
`endif
        end
        ST_READY: begin
          if (!in_range && req_any) begin
            dat_rd_q <= '0;
            err_q    <= 1'b1;
          end else if (dat_re != 4'h0) begin
            dat_rd_q <= mem_q[word_idx] & re_mask;
          end
        end
      endcase
    end
  end

  assign dat_rd    = dat_rd_q;
  assign err       = err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_u_dmem.sv
// Self-checking bench for u_dmem (AW=4) against a word-array reference model;
// covers both builds, with and without DMEM_CLEAR_EN.
module tb_u_dmem;

  localparam int AW    = 4;
  localparam int WORDS = 16;
`ifdef DMEM_CLEAR_EN
  localparam int INIT_CYCLES = 16;
`else
  localparam int INIT_CYCLES = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dat_a = '0;
  logic [3:0]  dat_we = '0;
  logic [31:0] dat_wd = '0;
  logic [3:0]  dat_re = '0;
  logic [31:0] dat_rd;
  logic        init_done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [WORDS];
  logic [31:0] rd_m;
  logic        err_m;

  u_dmem #(.AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .dat_a     (dat_a),
    .dat_we    (dat_we),
    .dat_wd    (dat_wd),
    .dat_re    (dat_re),
    .dat_rd    (dat_rd),
    .init_done (init_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dat_a  = '0;
    dat_we = '0;
    dat_wd = '0;
    dat_re = '0;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] en);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (en[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // One READY-state request: the model decides what the word array, dat_rd and err become.
  task automatic cycle(input logic [15:0] a, input logic [3:0] we, input logic [31:0] wd,
                       input logic [3:0] re);
    int idx;
    dat_a  = a;
    dat_we = we;
    dat_wd = wd;
    dat_re = re;
    idx    = (int'(a) / 4) % WORDS;
    err_m  = 1'b0;
    if (int'(a) < 4 * WORDS) begin
      if (re != 0) rd_m = mem_m[idx] & lanes(re);
      if (we != 0) mem_m[idx] = (mem_m[idx] & ~lanes(we)) | (wd & lanes(we));
    end else if (we != 0 || re != 0) begin
      rd_m  = '0;
      err_m = 1'b1;
    end
    tick();
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    dat_a  = 16'h0000;
    dat_we = 4'hF;
    dat_wd = $urandom;
    dat_re = 4'hF;
    tick();
    tick();
    total++;
    if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    total++;
    if (dat_rd !== 32'h0) begin bad++; $display("FAIL reset_dat_rd: got %h want 00000000", dat_rd); end
    idle();
  endtask

  task automatic test_init();
    int cycles;
    rst    = 1'b0;
    dat_a  = 16'h000C;
    dat_we = 4'hF;
    dat_wd = 32'hFFFF_FFFF;
    dat_re = 4'hF;
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (init_done === 1'b1) break;
      total++;
      if (err !== 1'b0 || dat_rd !== 32'h0) begin
        bad++;
        $display("FAIL init_quiet: cycle %0d got err=%b rd=%h want err=0 rd=00000000", cycles, err, dat_rd);
      end
    end
    idle();
    total++;
    if (cycles !== INIT_CYCLES || init_done !== 1'b1) begin
      bad++;
      $display("FAIL init_latency: got %0d cycles (init_done=%b) want %0d", cycles, init_done, INIT_CYCLES);
    end
    for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
    rd_m = '0;
`ifndef DMEM_CLEAR_EN
    for (int i = 0; i < WORDS; i++) cycle(16'(4 * i), 4'hF, 32'h0, 4'h0);
`endif
    for (int i = 0; i < WORDS; i++) begin
      cycle(16'(4 * i), 4'h0, 32'h0, 4'hF);
      total++;
      if (dat_rd !== 32'h0 || err !== 1'b0) begin
        bad++;
        $display("FAIL init_readback word %0d: got rd=%h err=%b want rd=00000000 err=0", i, dat_rd, err);
      end
    end
  endtask

  task automatic test_byte_write();
    cycle(16'h0010, 4'hF, 32'hDEAD_BEEF, 4'h0);
    cycle(16'h0010, 4'h1, 32'h0000_00AA, 4'h0);
    cycle(16'h0010, 4'h0, 32'h0, 4'hF);
    total++;
    if (dat_rd !== 32'hDEAD_BEAA) begin bad++; $display("FAIL byte_write: got %h want deadbeaa", dat_rd); end
  endtask

  task automatic test_read_first();
    cycle(16'h0020, 4'hF, 32'hCAFE_F00D, 4'h0);
    cycle(16'h0020, 4'hF, 32'h1234_5678, 4'hF);
    total++;
    if (dat_rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL read_first_old: got %h want cafef00d", dat_rd); end
    cycle(16'h0020, 4'h0, 32'h0, 4'hF);
    total++;
    if (dat_rd !== 32'h1234_5678) begin bad++; $display("FAIL read_first_new: got %h want 12345678", dat_rd); end
  endtask

  task automatic test_read_mask_hold();
    cycle(16'h0010, 4'hF, 32'hDEAD_BEEF, 4'h0);
    cycle(16'h0010, 4'h0, 32'h0, 4'b0110);
    total++;
    if (dat_rd !== 32'h00AD_BE00) begin bad++; $display("FAIL read_mask: got %h want 00adbe00", dat_rd); end
    for (int i = 0; i < 3; i++) begin
      cycle(16'h0014, (i == 1) ? 4'hF : 4'h0, 32'h5555_AAAA, 4'h0);
      total++;
      if (dat_rd !== 32'h00AD_BE00) begin
        bad++;
        $display("FAIL read_hold cycle %0d: got %h want 00adbe00", i, dat_rd);
      end
    end
  endtask

  task automatic test_out_of_range();
    cycle(16'h0000, 4'hF, 32'h1122_3344, 4'h0);
    cycle(16'h0040, 4'hF, 32'hFFFF_FFFF, 4'h0);
    total++;
    if (err !== 1'b1 || dat_rd !== 32'h0) begin
      bad++;
      $display("FAIL oor_write: got err=%b rd=%h want err=1 rd=00000000", err, dat_rd);
    end
    cycle(16'h0000, 4'h0, 32'h0, 4'h0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL oor_pulse_end: got err=%b want 0", err); end
    cycle(16'h0040, 4'h0, 32'h0, 4'hF);
    total++;
    if (err !== 1'b1 || dat_rd !== 32'h0) begin
      bad++;
      $display("FAIL oor_read: got err=%b rd=%h want err=1 rd=00000000", err, dat_rd);
    end
    cycle(16'h0000, 4'h0, 32'h0, 4'hF);
    total++;
    if (err !== 1'b0 || dat_rd !== 32'h1122_3344) begin
      bad++;
      $display("FAIL oor_word0: got err=%b rd=%h want err=0 rd=11223344", err, dat_rd);
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [3:0]  we;
    logic [3:0]  re;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(7) == 0) a = 16'($urandom_range(16'hFFFF, 16'h0040));
      else                        a = 16'($urandom_range(63));
      we = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      re = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      cycle(a, we, $urandom, re);
      total++;
      if (dat_rd !== rd_m || err !== err_m) begin
        bad++;
        $display("FAIL random op %0d a=%h we=%h re=%h: got rd=%h err=%b want rd=%h err=%b",
                 n, a, we, re, dat_rd, err, rd_m, err_m);
      end
    end
    idle();
  endtask

  task automatic test_reset_restart();
    int cycles;
`ifdef DMEM_CLEAR_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    total++;
    if (init_done !== 1'b0 || dat_rd !== 32'h0) begin
      bad++;
      $display("FAIL restart_in_reset: got init_done=%b rd=%h want 0 and 00000000", init_done, dat_rd);
    end
    rst    = 1'b0;
    dat_a  = 16'h0014;
    dat_we = 4'hF;
    dat_wd = 32'hFFFF_FFFF;
    cycles = 0;
    while (cycles < 100) begin
      tick();
      cycles++;
      if (init_done === 1'b1) break;
    end
    idle();
    total++;
    if (cycles !== 16) begin bad++; $display("FAIL restart_latency: got %0d cycles want 16", cycles); end
    for (int i = 0; i < WORDS; i++) mem_m[i] = '0;
    rd_m = '0;
    cycle(16'h0014, 4'h0, 32'h0, 4'hF);
    total++;
    if (dat_rd !== 32'h0) begin bad++; $display("FAIL restart_clear_write: got %h want 00000000", dat_rd); end
`else
    cycle(16'h0008, 4'hF, 32'h5A5A_1234, 4'h0);
    rst    = 1'b1;
    dat_a  = 16'h0008;
    dat_we = 4'hF;
    dat_wd = 32'hFFFF_FFFF;
    dat_re = 4'hF;
    tick();
    total++;
    if (init_done !== 1'b0 || dat_rd !== 32'h0 || err !== 1'b0) begin
      bad++;
      $display("FAIL restart_in_reset: got init_done=%b rd=%h err=%b want 0 00000000 0", init_done, dat_rd, err);
    end
    rst = 1'b0;
    tick();
    idle();
    total++;
    if (init_done !== 1'b1 || dat_rd !== 32'h0) begin
      bad++;
      $display("FAIL restart_ready: got init_done=%b rd=%h want 1 00000000", init_done, dat_rd);
    end
    rd_m = '0;
    cycle(16'h0008, 4'h0, 32'h0, 4'hF);
    total++;
    if (dat_rd !== 32'h5A5A_1234) begin bad++; $display("FAIL restart_dropped_write: got %h want 5a5a1234", dat_rd); end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_byte_write();
    test_read_first();
    test_read_mask_hold();
    test_out_of_range();
    test_random();
    test_reset_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/u_dmem.md
U_DMEM -- requirements
Module: u_dmem

Interface
REQ-001 SHALL have parameter AW, default 10, the log2 of the number of 32-bit words stored (1024 words).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port dat_a, input, 16 bits: byte address from the core data port; word index = dat_a[AW+1:2]; dat_a[1:0] ignored.
REQ-005 SHALL have port dat_we, input, 4 bits: per-byte write enables, bit i selecting dat_wd[8i+7:8i].
REQ-006 SHALL have port dat_wd, input, 32 bits: write data.
REQ-007 SHALL have port dat_re, input, 4 bits: per-byte read enables.
REQ-008 SHALL have port dat_rd, output, 32 bits: registered read data.
REQ-009 SHALL have port init_done, output, 1 bit: high once the block accepts requests.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse flagging an out-of-range access.

Function
REQ-011 SHALL hold 2^AW words of 32 bits in an internal array.
REQ-012 Address in range: dat_a[15:AW+2] == 0; any other address is out of range.
REQ-013 In READY with dat_we != 0 and address in range, SHALL update only the enabled byte lanes of the addressed word at the clock edge.
REQ-014 In READY with dat_re != 0, dat_rd SHALL present the addressed word on the next cycle (latency 1).
REQ-015 Byte lanes with dat_re bit clear SHALL read as 0x00.
REQ-016 When dat_re == 0, dat_rd SHALL hold its previous value.
REQ-017 Read and write to the same word in the same cycle: SHALL execute both, and dat_rd SHALL return the pre-write contents (read-first).
REQ-018 Out-of-range access with dat_we != 0 or dat_re != 0: SHALL drop the write, SHALL load dat_rd with 0, and SHALL pulse err high the following cycle.
REQ-019 err SHALL be 0 in every other cycle.
REQ-020 SHALL implement states CLEAR and READY.
REQ-021 In CLEAR, SHALL write 0 to word clr_idx each cycle, with clr_idx counting 0 .. 2^AW-1.
REQ-022 The cycle after writing word 2^AW-1, SHALL move CLEAR -> READY and set init_done = 1.
REQ-023 Requests arriving in CLEAR SHALL be ignored: no write, dat_rd stays 0, err stays 0.
REQ-024 READY is terminal until rst.

Reset
REQ-025 While rst == 1 at a clock edge: state <= CLEAR, clr_idx <= 0, dat_rd <= 0, err <= 0, init_done <= 0.
REQ-026 Array contents SHALL NOT be reset directly; they are cleared only by the CLEAR sequence.
REQ-027 Reset asserted mid-CLEAR or in READY SHALL restart the sequence from word 0.
REQ-028 A request coincident with rst SHALL be dropped.

Configuration
REQ-029 Macro DMEM_CLEAR_EN defined: SHALL implement the CLEAR sequence per REQ-021..023.
REQ-030 DMEM_CLEAR_EN undefined: SHALL enter READY on the first edge after rst deasserts.
REQ-031 DMEM_CLEAR_EN undefined: init_done SHALL be 1 from that edge, array contents are undefined until written, and there SHALL be no clear counter logic.

Verification
REQ-032 AW=4, DMEM_CLEAR_EN on: release rst, count cycles -> init_done rises exactly 16 cycles after release; then read all 16 words with dat_re=4'hF -> each returns 0x00000000.
REQ-033 Write 0xDEADBEEF with we=4'hF at 0x0010, then write 0x000000AA with we=4'h1, then read with re=4'hF -> dat_rd=0xDEADBEAA one cycle after the read.
REQ-034 Same cycle: write 0x12345678 and read 0x0020, which previously held 0xCAFEF00D -> dat_rd=0xCAFEF00D; next read -> 0x12345678.
REQ-035 Read 0x0010 holding 0xDEADBEEF with re=4'b0110 -> dat_rd=0x00ADBE00; then re=0 for 3 cycles -> dat_rd stays 0x00ADBE00.
REQ-036 AW=4: write then read to address 0x0040 -> write dropped, err pulses once per access, dat_rd=0; word 0 unchanged.
REQ-037 Assert rst at clr_idx=7 -> state returns to CLEAR, clr_idx=0, init_done=0; READY reached 16 cycles after release; a write issued during CLEAR has no effect.
